// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial-stream blocks (serializer, 110 detectors).
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Bit counter width able to hold 0..width (parity mode loads WIDTH).
    function automatic int ser_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding the 110 detectors; words stream back-to-back.
// Optional trailing even-parity bit per word when SER_PARITY_EN is defined.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = ser_cnt_width(WIDTH);
`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
`else
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
`endif

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic accept;
    logic next_bit;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        x_out_d   = x_out_q;
        x_valid_d = x_valid_q;
`ifdef SER_PARITY_EN
        par_d     = par_q;
`endif

        busy      = (state_q == SHIFT);
        done      = busy && (cnt_q == '0);
        din_ready = !busy || done;
        accept    = din_valid && din_ready;
        next_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

        if (accept) begin
            // Also covers the last-bit cycle, giving zero-gap streaming.
            x_out_d   = MSB_FIRST ? din[WIDTH-1] : din[0];
            shreg_d   = MSB_FIRST ? (din << 1) : (din >> 1);
            cnt_d     = CNT_LOAD;
            x_valid_d = 1'b1;
            state_d   = SHIFT;
`ifdef SER_PARITY_EN
            par_d     = ^din;
`endif
        end else if (busy && !done) begin
`ifdef SER_PARITY_EN
            x_out_d   = (cnt_q == CW'(1)) ? par_q : next_bit;
`else
            x_out_d   = next_bit;
`endif
            shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d     = cnt_q - CW'(1);
        end else if (done) begin
            state_d   = IDLE;
            x_valid_d = 1'b0;
            x_out_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
`ifdef SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// checked each cycle against a bit-queue reference model (honours SER_PARITY_EN).
module tb_piso_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         m_ready, m_x_out, m_x_valid, m_busy, m_done;
    logic         l_ready, l_x_out, l_x_valid, l_busy, l_done;

    int total = 0;
    int bad   = 0;

    // Reference model: bits still to appear on x_out, head = bit currently shown.
    bit q_m[$];
    bit q_l[$];
    bit exp_stream[$];
    bit last_acc;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
        .x_out(m_x_out), .x_valid(m_x_valid), .busy(m_busy), .done(m_done)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
        .x_out(l_x_out), .x_valid(l_x_valid), .busy(l_busy), .done(l_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            q_m.push_back(w[W-1-i]);
            q_l.push_back(w[i]);
            exp_stream.push_back(w[W-1-i]);
        end
`ifdef SER_PARITY_EN
        q_m.push_back(^w);
        q_l.push_back(^w);
        exp_stream.push_back(^w);
`endif
    endfunction

    function automatic void model_reset();
        q_m.delete();
        q_l.delete();
    endfunction

    function automatic logic [9:0] exp_vec();
        int  n;
        logic xo, lxo;
        n   = q_m.size();
        xo  = (n > 0) ? q_m[0] : 1'b0;
        lxo = (n > 0) ? q_l[0] : 1'b0;
        return {xo, n > 0, n <= 1, n > 0, n == 1, lxo, n > 0, n <= 1, n > 0, n == 1};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {m_x_out, m_x_valid, m_ready, m_busy, m_done,
                l_x_out, l_x_valid, l_ready, l_busy, l_done};
    endfunction

    function automatic int count_110(input bit s[$]);
        int c = 0;
        for (int i = 0; i + 2 < s.size(); i++)
            if (s[i] && s[i+1] && !s[i+2]) c++;
        return c;
    endfunction

    // Advance one clock and update the model; inputs are driven at posedge+1.
    task automatic step();
        logic [W-1:0] w;
        logic         acc;
        w   = din;
        acc = din_valid && (q_m.size() <= 1);
        @(posedge clk);
        #1;
        if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        if (acc) push_word(w);
        last_acc = acc;
    endtask

    task automatic test_reset();
        rst = 1'b0; din_valid = 1'b0; din = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_held got=%b exp=%b", obs_vec(), exp_vec());
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL idle_cycle%0d got=%b exp=%b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_word();
        logic [31:0] ms = '0, ls = '0;
        int xv_cnt = 0, done_cnt = 0;
        exp_stream.delete();
        din = 8'hD6; din_valid = 1'b1;
        for (int c = 0; c < NB + 3; c++) begin
            step();
            din_valid = 1'b0;
            din = W'($urandom);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single_cycle%0d got=%b exp=%b", c, obs_vec(), exp_vec());
            end
            if (m_x_valid) begin
                ms = {ms[30:0], m_x_out};
                ls[xv_cnt] = l_x_out;
                xv_cnt++;
            end
            if (m_done) begin
                done_cnt++;
                total++;
                if (c != NB - 1) begin
                    bad++;
                    $display("FAIL single_done_pos got=%0d exp=%0d", c, NB - 1);
                end
            end
        end
        total++;
        if (xv_cnt != NB) begin
            bad++;
            $display("FAIL single_xvalid_len got=%0d exp=%0d", xv_cnt, NB);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL single_done_count got=%0d exp=1", done_cnt);
        end
        total++;
        if (ms[NB-1 -: 8] !== 8'hD6) begin
            bad++;
            $display("FAIL single_msb_stream got=%h exp=d6", ms[NB-1 -: 8]);
        end
        total++;
        if (ls[7:0] !== 8'hD6) begin
            bad++;
            $display("FAIL single_lsb_stream got=%h exp=d6", ls[7:0]);
        end
`ifdef SER_PARITY_EN
        total++;
        if (ms[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_parity got=%b exp=1", ms[0]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[2] = '{8'h01, 8'h80};
        bit obs_s[$];
        int idx = 0, run = 0, max_run = 0;
        exp_stream.delete();
        for (int c = 0; c < 4 * NB; c++) begin
            din_valid = (idx < 2);
            din = (idx < 2) ? words[idx] : 8'h00;
            step();
            if (last_acc) idx++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_cycle%0d got=%b exp=%b", c, obs_vec(), exp_vec());
            end
            if (m_x_valid) begin
                obs_s.push_back(m_x_out);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        din_valid = 1'b0;
        total++;
        if (max_run != 2 * NB) begin
            bad++;
            $display("FAIL b2b_contiguous got=%0d exp=%0d", max_run, 2 * NB);
        end
        total++;
        if (obs_s != exp_stream) begin
            bad++;
            $display("FAIL b2b_stream got_len=%0d exp_len=%0d", obs_s.size(), exp_stream.size());
        end
        total++;
        if (count_110(obs_s) != 1 || count_110(exp_stream) != 1) begin
            bad++;
            $display("FAIL b2b_110_count got=%0d exp=1", count_110(obs_s));
        end
    endtask

    task automatic test_mid_reset();
        bit obs_s[$];
        int ones = 0;
        din = 8'hFF; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        total++;
        if (obs_vec() !== exp_vec() || !m_x_valid) begin
            bad++;
            $display("FAIL midrst_before got=%b exp=%b", obs_vec(), exp_vec());
        end
        #3 rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL midrst_async got=%b exp=%b", obs_vec(), exp_vec());
        end
        #2 rst = 1'b1;
        din = 8'h0F; din_valid = 1'b1;
        exp_stream.delete();
        for (int c = 0; c < NB + 4; c++) begin
            step();
            din_valid = 1'b0;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL midrst_after%0d got=%b exp=%b", c, obs_vec(), exp_vec());
            end
            if (m_x_valid) obs_s.push_back(m_x_out);
            ones += int'(m_x_out);
        end
        total++;
        if (ones != 4 || obs_s != exp_stream) begin
            bad++;
            $display("FAIL midrst_clean_word got_ones=%0d exp_ones=4", ones);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] words[$];
        bit obs_s[$];
        int idx = 0, gap = 0, cyc = 0;
        exp_stream.delete();
        for (int i = 0; i < 20; i++) words.push_back(W'($urandom));
        while ((idx < words.size() || q_m.size() > 0) && cyc < 600) begin
            if (idx < words.size() && gap == 0) begin
                din_valid = 1'b1;
                din = words[idx];
            end else begin
                din_valid = 1'b0;
                din = W'($urandom);
            end
            step();
            cyc++;
            if (last_acc) begin
                idx++;
                gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NB + 2) : 0;
            end else if (gap > 0) begin
                gap--;
            end
            if ($urandom_range(0, 1) == 1 && idx < words.size() && gap == 0 && q_m.size() > 1) begin
                din_valid = 1'b1;
            end
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_cycle%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (m_x_valid) obs_s.push_back(m_x_out);
        end
        din_valid = 1'b0;
        total++;
        if (idx != words.size() || q_m.size() != 0) begin
            bad++;
            $display("FAIL random_timeout got_words=%0d exp_words=%0d", idx, words.size());
        end
        total++;
        if (obs_s != exp_stream) begin
            bad++;
            $display("FAIL random_stream got_len=%0d exp_len=%0d", obs_s.size(), exp_stream.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out stage that sits directly upstream of the serial sequence detectors (110 family). It accepts WIDTH-bit words over a valid/ready handshake. It emits one bit per clock on x_out, which drives a detector's x_in. Back-to-back words stream with no gap, so patterns that span word boundaries remain detectable.

Parameters:
WIDTH, 8, bits per parallel word (legal range 2..32)
MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a word
din_ready  output  1  serializer can accept a word this cycle
x_out  output  1  serial bit, registered; feeds detector x_in
x_valid  output  1  x_out carries a word bit this cycle
busy  output  1  state == SHIFT
done  output  1  one-cycle pulse while the last bit of a word is on x_out

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst low forces reset immediately, independent of clk).
- Reset values: state=IDLE, shreg=0, cnt=0, x_out=0, x_valid=0, busy=0, done=0, din_ready=1.
- FSM states:
  - IDLE: no word in flight.
  - SHIFT: a word is being emitted.
- Control outputs (combinational from registers only; no input-to-output comb path):
  - din_ready = (state==IDLE) || (state==SHIFT && cnt==0).
  - done = (state==SHIFT && cnt==0).
  - busy = (state==SHIFT).
- Accept: occurs on a rising edge where din_valid && din_ready. At that edge:
  - x_out <= first bit (din[WIDTH-1] if MSB_FIRST, else din[0]).
  - x_valid <= 1.
  - shreg <= din shifted one position toward the output end.
  - cnt <= WIDTH-1.
  - state <= SHIFT.
- SHIFT with cnt!=0: each edge, x_out <= next bit from shreg, shreg shifts one position, cnt decrements.
- SHIFT with cnt==0 (last bit on x_out):
  - If din_valid is high, the new word is accepted as above; its first bit follows the previous last bit with zero gap.
  - Otherwise: state <= IDLE, x_valid <= 0, x_out <= 0.
- Latency: word accepted at edge k → bit 0 visible after edge k; bit i visible after edge k+i; last bit after edge k+WIDTH-1.
- Throughput: one word per WIDTH cycles when din_valid is held.
- din is sampled only at the accept edge; later changes to din are ignored.
- din_valid while not ready (mid-word, cnt!=0): no effect; the word is not captured; upstream must hold it.
- IDLE output: x_out held 0, so a downstream detector sees zeros and makes no spurious detections.
- Reset mid-word: the word is dropped and all outputs return to reset values asynchronously. After rst deasserts, the first edge with din_valid=1 accepts a new word.
- cnt width: $clog2(WIDTH+1) bits; must not wrap below 0.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - Each word emits WIDTH+1 bits: the data bits, then one even-parity bit (XOR of din captured at accept).
  - cnt loads WIDTH instead of WIDTH-1.
  - done and din_ready assert during the parity bit.
- Undefined: no parity logic is generated; exactly WIDTH bits per word, as described above.

Decomposition:
- Shared package ser_pkg:
  - state typedef (IDLE, SHIFT).
  - localparam function for the cnt width.
  - Common with other serial-stream blocks.
- Flat module; no sub-module is natural. Shift register, counter and two-state FSM fit in one file.
- The integration bench instantiates piso_serializer driving the 110 detector.

Test Plan:
- Reset/idle: rst low, then high, din_valid=0 → x_out=0, x_valid=0, din_ready=1, busy=0 for 10 cycles.
- Single word, MSB_FIRST=1, din=8'b1101_0110 pulsed valid → x_out=1,1,0,1,0,1,1,0 on 8 consecutive cycles; x_valid high exactly 8 cycles; done high only on cycle 8; then IDLE.
- Back-to-back words: din=8'h01 then 8'h80 with din_valid held → 16 contiguous x_valid cycles; stream 0000000110000000 (boundary "110" spans the words); downstream detector out pulses exactly once.
- LSB_FIRST: MSB_FIRST=0, din=8'h03 → x_out=1,1,0,0,0,0,0,0.
- Reset mid-word: load 8'hFF, drop rst low after the 3rd bit → x_valid=0, x_out=0, din_ready=1 asynchronously. After release, 8'h0F shifts out cleanly with no residual 1s.
- SER_PARITY_EN defined, din=8'h07 → 9 bits 0,0,0,0,0,1,1,1,1 (parity=1); done on bit 9.
